// File: rtl/beat_pkg.sv
// Shared types for the beat detector.
// Holds the slope-tracking FSM state encoding.
package beat_pkg;

    typedef enum logic [1:0] {
        INIT,
        RISING,
        FALLING
    } beat_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset and sync clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Next count: clear wins, increment stops at all-ones
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + N'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/beat_detector.sv
// Peak/trough detector with amplitude hysteresis, peak refractory
// window and inter-peak interval measurement.
module beat_detector
    import beat_pkg::*;
#(
    parameter int W       = 10,
    parameter int HYST    = 8,
    parameter int MIN_GAP = 4,
    parameter int CNT_W   = 10,
    parameter int IW      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [W-1:0]     sample,
    output logic             peak_pulse,
    output logic             trough_pulse,
    output logic [CNT_W-1:0] peak_count,
    output logic [CNT_W-1:0] trough_count,
    output logic [IW-1:0]    interval,
    output logic             interval_valid
);

    localparam logic [W-1:0]  HYST_W    = W'(HYST);
    localparam logic [IW-1:0] MIN_GAP_W = IW'(MIN_GAP);

    beat_state_t   state_q, state_d;
    logic [W-1:0]  ext_q, ext_d;
    logic [IW-1:0] gap_q, gap_d;
    logic          have_peak_q, have_peak_d;
    logic [IW-1:0] interval_q, interval_d;
    logic          interval_valid_q, interval_valid_d;
    logic          peak_pulse_q, peak_pulse_d;
    logic          trough_pulse_q, trough_pulse_d;
    logic [IW-1:0] gap_next;
    logic          cand;

    // Track the running extreme, classify turns and apply refractory
    always_comb begin
        state_d          = state_q;
        ext_d            = ext_q;
        gap_d            = gap_q;
        have_peak_d      = have_peak_q;
        interval_d       = interval_q;
        interval_valid_d = interval_valid_q;
        peak_pulse_d     = 1'b0;
        trough_pulse_d   = 1'b0;
        cand             = 1'b0;
        gap_next         = (gap_q == '1) ? gap_q : gap_q + IW'(1);

        if (clear) begin
            state_d          = INIT;
            gap_d            = '0;
            have_peak_d      = 1'b0;
            interval_d       = '0;
            interval_valid_d = 1'b0;
        end else if (sample_valid) begin
            case (state_q)
                INIT: begin
                    ext_d   = sample;
                    state_d = RISING;
                end
                RISING: begin
                    if (sample > ext_q) begin
                        ext_d = sample;
                    end else if ((ext_q - sample) >= HYST_W) begin
                        cand    = 1'b1;
                        ext_d   = sample;
                        state_d = FALLING;
                    end
                end
                FALLING: begin
                    if (sample < ext_q) begin
                        ext_d = sample;
                    end else if ((sample - ext_q) >= HYST_W) begin
                        trough_pulse_d = 1'b1;
                        ext_d          = sample;
                        state_d        = RISING;
                    end
                end
                default: begin
                    state_d = INIT;
                end
            endcase

            if (cand && ((gap_next >= MIN_GAP_W) || !have_peak_q)) begin
                peak_pulse_d = 1'b1;
                gap_d        = '0;
                if (have_peak_q) begin
                    interval_d       = gap_next;
                    interval_valid_d = 1'b1;
                end
                have_peak_d = 1'b1;
            end else begin
                gap_d = gap_next;
            end
        end
    end

    // Detector state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= INIT;
            ext_q            <= '0;
            gap_q            <= '0;
            have_peak_q      <= 1'b0;
            interval_q       <= '0;
            interval_valid_q <= 1'b0;
            peak_pulse_q     <= 1'b0;
            trough_pulse_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            ext_q            <= ext_d;
            gap_q            <= gap_d;
            have_peak_q      <= have_peak_d;
            interval_q       <= interval_d;
            interval_valid_q <= interval_valid_d;
            peak_pulse_q     <= peak_pulse_d;
            trough_pulse_q   <= trough_pulse_d;
        end
    end

    sat_counter #(.N(CNT_W)) u_peak_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (peak_pulse_d),
        .q     (peak_count)
    );

    sat_counter #(.N(CNT_W)) u_trough_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (trough_pulse_d),
        .q     (trough_count)
    );

    assign peak_pulse     = peak_pulse_q;
    assign trough_pulse   = trough_pulse_q;
    assign interval       = interval_q;
    assign interval_valid = interval_valid_q;

endmodule

// File: tb/tb_beat_detector.sv
// Self-checking bench for beat_detector: directed vector table,
// hand sequences for saturation/clear/reset, and a random model run.
module tb_beat_detector;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        sample_valid;
    logic [9:0]  sample;

    logic        pp, tp, iv;
    logic [9:0]  pc, tc;
    logic [11:0] intv;

    logic        pp2, tp2, iv2;
    logic [1:0]  pc2, tc2;
    logic [11:0] intv2;

    int n_checks = 0;
    int n_err    = 0;

    beat_detector dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .peak_pulse     (pp),
        .trough_pulse   (tp),
        .peak_count     (pc),
        .trough_count   (tc),
        .interval       (intv),
        .interval_valid (iv)
    );

    beat_detector #(.CNT_W(2)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .peak_pulse     (pp2),
        .trough_pulse   (tp2),
        .peak_count     (pc2),
        .trough_count   (tc2),
        .interval       (intv2),
        .interval_valid (iv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: mode 0=waiting first sample, 1=climbing, 2=descending
    int m_mode, m_ext, m_gap, m_have, m_int, m_iv, m_pc, m_tc, m_pp, m_tp;

    task automatic model_reset();
        m_mode = 0; m_ext = 0; m_gap = 0; m_have = 0;
        m_int = 0; m_iv = 0; m_pc = 0; m_tc = 0; m_pp = 0; m_tp = 0;
    endtask

    task automatic model_step(input bit v, input bit c, input int s);
        int g;
        bit turn_down;
        m_pp = 0;
        m_tp = 0;
        if (c) begin
            m_mode = 0; m_gap = 0; m_have = 0;
            m_int = 0; m_iv = 0; m_pc = 0; m_tc = 0;
        end else if (v) begin
            g = (m_gap + 1 > 4095) ? 4095 : m_gap + 1;
            turn_down = 0;
            if (m_mode == 0) begin
                m_ext = s; m_mode = 1;
            end else if (m_mode == 1) begin
                if (s > m_ext) m_ext = s;
                else if (m_ext - s >= 8) begin
                    turn_down = 1; m_ext = s; m_mode = 2;
                end
            end else begin
                if (s < m_ext) m_ext = s;
                else if (s - m_ext >= 8) begin
                    m_tp = 1; m_tc++; m_ext = s; m_mode = 1;
                end
            end
            if (turn_down && (g >= 4 || m_have == 0)) begin
                m_pp = 1; m_pc++; m_gap = 0;
                if (m_have != 0) begin
                    m_int = g; m_iv = 1;
                end
                m_have = 1;
            end else begin
                m_gap = g;
            end
        end
    endtask

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit v, input bit c, input int s);
        sample_valid = v;
        clear        = c;
        sample       = s[9:0];
        model_step(v, c, s);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    typedef struct {
        bit v;
        bit c;
        int s;
        int pp;
        int tp;
        int pc;
        int tc;
        int intv;
        int iv;
        int pc2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, bit c, int s, int epp, int etp,
                                int epc, int etc, int ein, int eiv, int epc2);
        vec_t r;
        r.v = v; r.c = c; r.s = s; r.pp = epp; r.tp = etp;
        r.pc = epc; r.tc = etc; r.intv = ein; r.iv = eiv; r.pc2 = epc2;
        return r;
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_pp"}, int'(pp), m_pp);
        chk({tag, "_tp"}, int'(tp), m_tp);
        chk({tag, "_pc"}, int'(pc), sat(m_pc, 1023));
        chk({tag, "_tc"}, int'(tc), sat(m_tc, 1023));
        chk({tag, "_int"}, int'(intv), m_int);
        chk({tag, "_iv"}, int'(iv), m_iv);
        chk({tag, "_pc2"}, int'(pc2), sat(m_pc, 3));
        chk({tag, "_tc2"}, int'(tc2), sat(m_tc, 3));
    endtask

    initial begin
        int cur;
        reset        = 1'b1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pp", int'(pp), 0);
        chk("rst_tp", int'(tp), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_int", int'(intv), 0);
        chk("rst_iv", int'(iv), 0);
        reset = 1'b0;

        // v c s | pp tp pc tc int iv pc2
        tbl.push_back(mk(1, 0, 100, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 120, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 140, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 130, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 90,  0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 80,  0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 95,  0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 300, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 100, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 140, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 130, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 150, 0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 160, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 150, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 170, 0, 1, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 175, 0, 0, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 180, 0, 0, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 185, 0, 0, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 190, 0, 0, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 195, 0, 0, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 185, 1, 0, 2, 2, 10, 1, 2));
        tbl.push_back(mk(0, 0, 0,   0, 0, 2, 2, 10, 1, 2));
        tbl.push_back(mk(1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 100, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 110, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 105, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 112, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 106, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 95,  1, 0, 1, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(tbl[i].v, tbl[i].c, tbl[i].s);
            chk({tag, "_pp"}, int'(pp), tbl[i].pp);
            chk({tag, "_tp"}, int'(tp), tbl[i].tp);
            chk({tag, "_pc"}, int'(pc), tbl[i].pc);
            chk({tag, "_tc"}, int'(tc), tbl[i].tc);
            chk({tag, "_int"}, int'(intv), tbl[i].intv);
            chk({tag, "_iv"}, int'(iv), tbl[i].iv);
            chk({tag, "_pc2"}, int'(pc2), tbl[i].pc2);
        end

        // Five accepted peaks: narrow counters pin at 3
        apply(1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            apply(1, 0, 200);
            apply(1, 0, 180);
            chk($sformatf("sat_pk%0d", k), int'(pp), 1);
            apply(1, 0, 170);
            apply(1, 0, 190);
            apply(1, 0, 195);
        end
        chk("sat_pc", int'(pc), 5);
        chk("sat_tc", int'(tc), 5);
        chk("sat_pc2", int'(pc2), 3);
        chk("sat_tc2", int'(tc2), 3);
        chk("sat_int", int'(intv), 5);
        chk("sat_iv", int'(iv), 1);

        // Clear beats a valid sample on the same cycle
        apply(1, 1, 900);
        chk("clr_pc", int'(pc), 0);
        chk("clr_pc2", int'(pc2), 0);
        chk("clr_tc2", int'(tc2), 0);
        chk("clr_iv", int'(iv), 0);
        chk("clr_int", int'(intv), 0);
        apply(1, 0, 100);
        chk("clr_nopk", int'(pp), 0);
        apply(1, 0, 90);
        chk("clr_pk", int'(pp), 1);
        chk("clr_pc1", int'(pc), 1);

        // Asynchronous reset in the middle of a cycle
        apply(1, 0, 150);
        apply(1, 0, 160);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_pc", int'(pc), 0);
        chk("arst_tc", int'(tc), 0);
        chk("arst_iv", int'(iv), 0);
        chk("arst_pp", int'(pp), 0);
        chk("arst_tp", int'(tp), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(1, 0, 50);
        chk("arst_first", int'(pp), 0);
        chk("arst_first_tp", int'(tp), 0);
        apply(1, 0, 40);
        chk("arst_pk", int'(pp), 1);
        chk("arst_pc1", int'(pc), 1);

        // Random walk against the reference model
        cur = 500;
        for (int n = 0; n < 1500; n++) begin
            bit v, c;
            cur = cur + int'($urandom_range(0, 40)) - 20;
            if (cur < 0) cur = 0;
            if (cur > 1023) cur = 1023;
            v = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 199) == 0);
            apply(v, c, cur);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
